// File: rtl/i2c_txn_sched.sv
// Round-robin transaction scheduler in front of the I2C core: arbitrates two
// requesters and sequences START+ADDR, WRITE/READ and STOP with a per-command timeout.
module i2c_txn_sched #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                   i2c_core_clk_i,
    input  logic                   i2c_core_rst_i,
    input  logic [1:0]             req_valid_i,
    input  logic [2*ADDR_SIZE-1:0] req_addr_rw_i,
    input  logic [2*DATA_SIZE-1:0] req_data_i,
    output logic [1:0]             req_ready_o,
    output logic [1:0]             resp_valid_o,
    output logic [DATA_SIZE-1:0]   resp_data_o,
    output logic [1:0]             resp_status_o,
    output logic [7:0]             command_o,
    output logic                   command_valid_o,
    output logic [ADDR_SIZE-1:0]   slave_addr_rw_o,
    output logic [DATA_SIZE-1:0]   data_transmit_o,
    input  logic                   core_done_i,
    input  logic                   core_ack_i,
    input  logic [DATA_SIZE-1:0]   core_rdata_i,
    output logic                   busy_o
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h04;
    localparam logic [7:0] CMD_STOP  = 8'h08;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_ADDR_NACK = 2'b01;
    localparam logic [1:0] ST_DATA_NACK = 2'b10;
    localparam logic [1:0] ST_TIMEOUT   = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        ISS_START,
        WAIT_ADDR,
        ISS_DATA,
        WAIT_DATA,
        ISS_STOP,
        WAIT_STOP,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [1:0]  status_q;
    logic [15:0] tmo_cnt_q;
    logic        grant_sel;
    logic        is_read;
    logic        in_wait;
    logic        timed_out;

    assign is_read   = slave_addr_rw_o[0];
    assign grant_sel = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
    assign in_wait   = state_q inside {WAIT_ADDR, WAIT_DATA, WAIT_STOP};
    // A done in the same cycle as the limit always takes precedence.
    assign timed_out = in_wait && !core_done_i && (tmo_cnt_q >= TIMEOUT_LAST);
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
        if (i2c_core_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready_o     = '0;
        command_valid_o = 1'b0;
        command_o       = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) state_d = ARB;
            end
            ARB: begin
                if (|req_valid_i) begin
                    req_ready_o = grant_sel ? 2'b10 : 2'b01;
                    state_d     = ISS_START;
                end else begin
                    state_d = IDLE;
                end
            end
            ISS_START: begin
                command_valid_o = 1'b1;
                command_o       = CMD_START;
                state_d         = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                if (core_done_i) state_d = core_ack_i ? ISS_DATA : ISS_STOP;
                else if (timed_out) state_d = ISS_STOP;
            end
            ISS_DATA: begin
                command_valid_o = 1'b1;
                command_o       = is_read ? CMD_READ : CMD_WRITE;
                state_d         = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (core_done_i || timed_out) state_d = ISS_STOP;
            end
            ISS_STOP: begin
                command_valid_o = 1'b1;
                command_o       = CMD_STOP;
                state_d         = WAIT_STOP;
            end
            WAIT_STOP: begin
                if (core_done_i || timed_out) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
        if (i2c_core_rst_i) begin
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            slave_addr_rw_o <= '0;
            data_transmit_o <= '0;
            status_q        <= ST_OK;
            tmo_cnt_q       <= '0;
            resp_data_o     <= '0;
            resp_valid_o    <= '0;
            resp_status_o   <= ST_OK;
        end else begin
            resp_valid_o <= '0;
            case (state_q)
                ARB: begin
                    if (|req_valid_i) begin
                        owner_q         <= grant_sel;
                        last_grant_q    <= grant_sel;
                        slave_addr_rw_o <= grant_sel ? req_addr_rw_i[ADDR_SIZE +: ADDR_SIZE]
                                                     : req_addr_rw_i[0 +: ADDR_SIZE];
                        data_transmit_o <= grant_sel ? req_data_i[DATA_SIZE +: DATA_SIZE]
                                                     : req_data_i[0 +: DATA_SIZE];
                    end
                end
                ISS_START, ISS_DATA, ISS_STOP: begin
                    tmo_cnt_q <= '0;
                end
                WAIT_ADDR: begin
                    if (core_done_i) begin
                        if (!core_ack_i) status_q <= ST_ADDR_NACK;
                    end else if (timed_out) begin
                        status_q <= ST_TIMEOUT;
                    end
                end
                WAIT_DATA: begin
                    if (core_done_i) begin
                        if (is_read) resp_data_o <= core_rdata_i;
                        else if (!core_ack_i) status_q <= ST_DATA_NACK;
                    end else if (timed_out) begin
                        status_q <= ST_TIMEOUT;
                    end
                end
                WAIT_STOP: begin
                    if (timed_out) status_q <= ST_TIMEOUT;
                end
                RESP: begin
                    resp_valid_o  <= owner_q ? 2'b10 : 2'b01;
                    resp_status_o <= status_q;
                    status_q      <= ST_OK;
                end
                default: begin
                end
            endcase
            if (in_wait && (tmo_cnt_q != '1)) tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Randomised bench for i2c_txn_sched: a transaction-level model of the core and
// requesters predicts grant order, command sequence, timing, status and read data.
module tb_i2c_txn_sched;

    localparam int unsigned TMO = 8;
    localparam logic [7:0] C_START = 8'h01;
    localparam logic [7:0] C_WRITE = 8'h02;
    localparam logic [7:0] C_READ  = 8'h04;
    localparam logic [7:0] C_STOP  = 8'h08;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_addr_rw;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;
    logic [7:0]  command;
    logic        command_valid;
    logic [7:0]  slave_addr_rw;
    logic [7:0]  data_transmit;
    logic        core_done;
    logic        core_ack;
    logic [7:0]  core_rdata;
    logic        busy;

    logic        rst_v;
    logic [1:0]  pend;
    logic [7:0]  addr_v [2];
    logic [7:0]  data_v [2];
    int          last_g;
    logic [7:0]  exp_rdata;
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    i2c_txn_sched #(
        .DATA_SIZE(8),
        .ADDR_SIZE(8),
        .TIMEOUT(TMO)
    ) dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_i (rst),
        .req_valid_i    (req_valid),
        .req_addr_rw_i  (req_addr_rw),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .resp_valid_o   (resp_valid),
        .resp_data_o    (resp_data),
        .resp_status_o  (resp_status),
        .command_o      (command),
        .command_valid_o(command_valid),
        .slave_addr_rw_o(slave_addr_rw),
        .data_transmit_o(data_transmit),
        .core_done_i    (core_done),
        .core_ack_i     (core_ack),
        .core_rdata_i   (core_rdata),
        .busy_o         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    // One clock cycle: drive inputs on the falling edge, observe 1 ns later.
    task automatic step(input logic d, input logic a, input logic [7:0] rd);
        @(negedge clk);
        rst         = rst_v;
        req_valid   = pend;
        req_addr_rw = {addr_v[1], addr_v[0]};
        req_data    = {data_v[1], data_v[0]};
        core_done   = d;
        core_ack    = a;
        core_rdata  = rd;
        #1;
    endtask

    task automatic do_txn(input logic [1:0] add, input logic [7:0] a0, input logic [7:0] d0,
                          input logic [7:0] a1, input logic [7:0] d1,
                          input int lat_fix, input logic [7:0] rd_fix, output int steps);
        int         win;
        int         other;
        int         lat;
        int         status;
        logic       held;
        logic       got;
        logic       fin;
        logic       first;
        logic       to;
        logic       ack;
        logic       spur;
        logic [7:0] rd;
        logic [7:0] cmd;
        logic [7:0] ea;
        logic [7:0] ew;
        steps = 0;
        held  = |pend;
        if (add[0] && !pend[0]) begin addr_v[0] = a0; data_v[0] = d0; pend[0] = 1'b1; end
        if (add[1] && !pend[1]) begin addr_v[1] = a1; data_v[1] = d1; pend[1] = 1'b1; end
        if (pend == 2'b00) begin addr_v[0] = a0; data_v[0] = d0; pend[0] = 1'b1; end
        win = (pend == 2'b11) ? (1 - last_g) : (pend[1] ? 1 : 0);
        other = 1 - win;

        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(1'b0, 1'b0, 8'h00);
            steps++;
            if (req_ready != 2'b00) got = 1'b1;
        end
        check("ready_latency", 64'(steps), held ? 64'd1 : 64'd2);
        check("ready_grant", 64'(req_ready), 64'(oh(win)));
        check("busy_in_arb", 64'(busy), 64'd1);
        if (!got) return;

        last_g = win;
        pend[win] = 1'b0;
        ea = addr_v[win];
        ew = data_v[win];
        status = 0;
        cmd = C_START;
        fin = 1'b0;
        first = 1'b1;
        while (!fin) begin
            spur = (lat_fix == 0) && ($urandom_range(0, 3) == 0);
            step(spur, 1'b0, 8'hEE);
            steps++;
            check("cmd_valid", 64'(command_valid), 64'd1);
            check("cmd_code", 64'(command), 64'(cmd));
            check("addr_hold", 64'(slave_addr_rw), 64'(ea));
            check("wdata_hold", 64'(data_transmit), 64'(ew));
            if (first) check("ready_one_pulse", 64'(req_ready), 64'd0);
            first = 1'b0;
            if (lat_fix == 0 && !pend[other] && $urandom_range(0, 7) == 0) begin
                addr_v[other] = 8'($urandom);
                data_v[other] = 8'($urandom);
                pend[other]   = 1'b1;
            end
            to  = (lat_fix == 0) && ($urandom_range(0, 9) == 0);
            lat = (lat_fix != 0) ? lat_fix :
                  (($urandom_range(0, 5) == 0) ? int'(TMO) : int'($urandom_range(1, 4)));
            ack = (lat_fix != 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
            rd  = (lat_fix != 0) ? rd_fix : 8'($urandom);
            if (to) begin
                for (int k = 0; k < int'(TMO); k++) begin
                    step(1'b0, 1'b0, 8'h00);
                    steps++;
                end
                check("timeout_quiet", 64'(command_valid), 64'd0);
                status = 3;
                if (cmd == C_STOP) fin = 1'b1;
                else cmd = C_STOP;
            end else begin
                for (int k = 1; k < lat; k++) begin
                    step(1'b0, 1'b0, 8'h00);
                    steps++;
                end
                step(1'b1, ack, rd);
                steps++;
                case (cmd)
                    C_START: begin
                        if (ack) cmd = ea[0] ? C_READ : C_WRITE;
                        else begin status = 1; cmd = C_STOP; end
                    end
                    C_READ: begin exp_rdata = rd; cmd = C_STOP; end
                    C_WRITE: begin if (!ack) status = 2; cmd = C_STOP; end
                    default: fin = 1'b1;
                endcase
            end
        end
        spur = (lat_fix == 0) && ($urandom_range(0, 3) == 0);
        step(spur, 1'b1, 8'hEE);
        steps++;
        check("resp_not_early", 64'(resp_valid), 64'd0);
        check("no_cmd_in_resp", 64'(command_valid), 64'd0);
        step(1'b0, 1'b0, 8'h00);
        steps++;
        check("resp_valid", 64'(resp_valid), 64'(oh(win)));
        check("resp_status", 64'(resp_status), 64'(status));
        check("resp_data", 64'(resp_data), 64'(exp_rdata));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         st;
        logic       got;
        logic [1:0] add;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        rst_v       = 1'b1;
        pend        = 2'b00;
        addr_v[0]   = 8'h00; addr_v[1] = 8'h00;
        data_v[0]   = 8'h00; data_v[1] = 8'h00;
        req_valid   = 2'b00;
        req_addr_rw = '0;
        req_data    = '0;
        core_done   = 1'b0;
        core_ack    = 1'b0;
        core_rdata  = 8'h00;
        last_g      = 1;
        exp_rdata   = 8'h00;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        check("reset_outputs", 64'({busy, command_valid, command, req_ready, resp_valid,
                                    resp_status, resp_data, slave_addr_rw, data_transmit}), 64'd0);
        rst_v = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        check("idle_after_reset", 64'(busy), 64'd0);

        do_txn(2'b01, 8'hA0, 8'h5A, 8'h00, 8'h00, 3, 8'h00, st);
        do_txn(2'b10, 8'h00, 8'h00, 8'hA1, 8'h00, 3, 8'h3C, st);
        do_txn(2'b01, 8'h50, 8'h77, 8'h00, 8'h00, 1, 8'h00, st);
        check("fastest_resp_cycle", 64'(st), 64'd10);

        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, st);

        for (int i = 0; i < 50; i++) begin
            add = 2'($urandom_range(0, 3));
            do_txn(add, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, st);
        end

        for (int i = 0; i < 3 && pend != 2'b00; i++)
            do_txn(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, st);

        // Interrupt a requester-0 write in WAIT_DATA, then re-request from both.
        addr_v[0] = 8'hA0;
        data_v[0] = 8'h11;
        pend = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (req_ready != 2'b00) got = 1'b1;
        end
        check("rst_pre_grant", 64'(req_ready), 64'd1);
        pend = 2'b00;
        step(1'b0, 1'b0, 8'h00);
        check("rst_pre_start", 64'(command), 64'(C_START));
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("rst_pre_write", 64'(command), 64'(C_WRITE));
        rst_v = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        check("rst_mid_outputs", 64'({busy, command_valid, command, req_ready, resp_valid,
                                      resp_status, resp_data, slave_addr_rw, data_transmit}), 64'd0);
        addr_v[0] = 8'h42; data_v[0] = 8'h24;
        addr_v[1] = 8'h43; data_v[1] = 8'h34;
        pend = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h00);
            check("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        last_g = 1;
        exp_rdata = 8'h00;
        rst_v = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (req_ready != 2'b00) got = 1'b1;
        end
        check("rst_regrant_req0", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
